key_schedule_ctrl: RTL and testbench

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

---
 rtl/key_schedule_ctrl.sv | 174 +++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller: expands one cipher key into 11 round keys,
// one round per cycle through a shared datapath, with a registered read port.
module key_schedule_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         abort,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    input  logic         rd_dir,
    output logic [127:0] rd_key
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state_r, state_s;
    logic [3:0]     rnd_r;
    logic [127:0]   rk_r [0:10];
    logic           done_r, keys_valid_r;
    logic [127:0]   rd_key_r;
    logic           load_s, step_s, finish_s, clr_valid_s;
    logic [127:0]   prev_s, next_s;
    logic [31:0]    t_s, w0_s, w1_s, w2_s, w3_s;
    logic [3:0]     eff_s;

    // Source round key for the current step; guarded so rnd_r=0 never indexes out of range.
    always_comb begin
        if ((rnd_r != 4'd0) && (rnd_r <= LAST_RND)) begin
            prev_s = rk_r[rnd_r - 4'd1];
        end else begin
            prev_s = 128'h0;
        end
    end

    // Single-round expansion datapath.
    always_comb begin
        t_s    = sub_word({prev_s[23:0], prev_s[31:24]}) ^ {rcon(rnd_r), 24'h000000};
        w0_s   = prev_s[127:96] ^ t_s;
        w1_s   = prev_s[95:64] ^ w0_s;
        w2_s   = prev_s[63:32] ^ w1_s;
        w3_s   = prev_s[31:0] ^ w2_s;
        next_s = {w0_s, w1_s, w2_s, w3_s};
    end

    // Next-state and step strobes; abort always wins over start.
    always_comb begin
        state_s     = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        clr_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (abort) begin
                    clr_valid_s = 1'b1;
                end else if (start) begin
                    load_s      = 1'b1;
                    clr_valid_s = 1'b1;
                    state_s     = EXPAND;
                end else begin
                    state_s = IDLE;
                end
            end
            EXPAND: begin
                if (abort) begin
                    state_s = IDLE;
                end else begin
                    step_s = 1'b1;
                    if (rnd_r == LAST_RND) begin
                        finish_s = 1'b1;
                        state_s  = IDLE;
                    end else begin
                        state_s = EXPAND;
                    end
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Control state, status flags and read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            rnd_r        <= 4'd0;
            done_r       <= 1'b0;
            keys_valid_r <= 1'b0;
            rd_key_r     <= 128'h0;
        end else begin
            state_r <= state_s;
            if (load_s) begin
                rnd_r <= 4'd1;
            end else if (state_s == IDLE) begin
                rnd_r <= 4'd0;
            end else if (step_s) begin
                rnd_r <= rnd_r + 4'd1;
            end
            done_r <= finish_s;
            if (finish_s) begin
                keys_valid_r <= 1'b1;
            end else if (clr_valid_s) begin
                keys_valid_r <= 1'b0;
            end
            rd_key_r <= (rd_idx > LAST_RND) ? 128'h0 : rk_r[eff_s];
        end
    end

    // Reverse order serves decryption; out-of-range indices are caught before use.
    always_comb begin
        if (rd_dir) begin
            eff_s = LAST_RND - rd_idx;
        end else begin
            eff_s = rd_idx;
        end
    end

    // Round-key store, deliberately left without reset.
    always_ff @(posedge clk) begin
        if (load_s) begin
            rk_r[0] <= key_in;
        end else if (step_s) begin
            rk_r[rnd_r] <= next_s;
        end
    end

    assign ready      = (state_r == IDLE);
    assign busy       = (state_r == EXPAND);
    assign done       = done_r;
    assign keys_valid = keys_valid_r;
    assign rd_key     = rd_key_r;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl using FIPS-197 reference round keys.
module tb_key_schedule_ctrl;

    localparam logic [127:0] K_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_FIPS_1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K_FIPS_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_SEQ    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_SEQ_A  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         rst_n, start, abort, rd_dir;
    logic [127:0] key_in;
    logic [3:0]   rd_idx;
    logic         ready, busy, done, keys_valid;
    logic [127:0] rd_key;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [127:0] exp_q [$];

    key_schedule_ctrl #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .abort(abort),
        .ready(ready), .busy(busy), .done(done), .keys_valid(keys_valid),
        .rd_idx(rd_idx), .rd_dir(rd_dir), .rd_key(rd_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_exp(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 128'(done), 128'(1));
        chk({tag, "_latency"}, 128'(cyc - acc_cyc + 1), 128'(11));
        chk({tag, "_valid"}, 128'(keys_valid), 128'(1));
    endtask

    // Scoreboard read: expectation queued on drive, popped when rd_key updates.
    task automatic rd(input string tag, input logic [3:0] idx, input logic dir,
                      input logic [127:0] e);
        rd_idx = idx;
        rd_dir = dir;
        exp_q.push_back(e);
        tick();
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 128'(0), 128'(1));
        end else begin
            chk(tag, rd_key, exp_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; rd_dir = 1'b0;
        rd_idx = 4'd0; key_in = 128'h0;
        tick(); tick();
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_valid", 128'(keys_valid), 128'(0));
        chk("rst_rdkey", rd_key, 128'h0);
        rst_n = 1'b1;
        tick();

        // FIPS-197 expansion
        start_exp(K_FIPS);
        chk("exp_busy", 128'(busy), 128'(1));
        chk("exp_ready", 128'(ready), 128'(0));
        chk("exp_valid", 128'(keys_valid), 128'(0));
        wait_done("fips");
        chk("fips_ready", 128'(ready), 128'(1));
        tick();
        chk("done_pulse", 128'(done), 128'(0));
        rd("fwd0", 4'd0, 1'b0, K_FIPS);
        rd("fwd1", 4'd1, 1'b0, K_FIPS_1);
        rd("fwd10", 4'd10, 1'b0, K_FIPS_A);
        rd("rev0", 4'd0, 1'b1, K_FIPS_A);
        rd("rev9", 4'd9, 1'b1, K_FIPS_1);
        rd("rev10", 4'd10, 1'b1, K_FIPS);
        rd("fwd12", 4'd12, 1'b0, 128'h0);
        rd("rev12", 4'd12, 1'b1, 128'h0);
        rd("fwd15", 4'd15, 1'b0, 128'h0);

        // start during EXPAND is ignored
        start_exp(K_SEQ);
        repeat (3) tick();
        start = 1'b1; key_in = K_FIPS;
        tick();
        start = 1'b0;
        chk("ign_busy", 128'(busy), 128'(1));
        wait_done("ign");
        // back-to-back start accepted in the done cycle
        start_exp(K_FIPS);
        chk("b2b_valid", 128'(keys_valid), 128'(0));
        chk("b2b_busy", 128'(busy), 128'(1));
        wait_done("b2b");
        rd("b2b_rk1", 4'd1, 1'b0, K_FIPS_1);
        rd("b2b_rk10", 4'd10, 1'b0, K_FIPS_A);

        // abort in IDLE with simultaneous start clears valid, stays IDLE
        start = 1'b1; abort = 1'b1; key_in = K_SEQ;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_ready", 128'(ready), 128'(1));
        chk("sa_busy", 128'(busy), 128'(0));
        chk("sa_valid", 128'(keys_valid), 128'(0));
        tick();
        chk("sa_stay", 128'(ready), 128'(1));

        // abort mid-expansion
        start_exp(K_SEQ);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_ready", 128'(ready), 128'(1));
        chk("ab_busy", 128'(busy), 128'(0));
        chk("ab_valid", 128'(keys_valid), 128'(0));
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n_done++;
            tick();
        end
        chk("ab_nodone", 128'(n_done), 128'(0));

        // fully expand K_SEQ so rd_key is nonzero, then reset mid-expansion
        start_exp(K_SEQ);
        wait_done("seq");
        rd("seq_rk10", 4'd10, 1'b0, K_SEQ_A);
        rd("seq_rk0", 4'd0, 1'b0, K_SEQ);
        start_exp(K_FIPS);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 128'(ready), 128'(1));
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_done", 128'(done), 128'(0));
        chk("arst_valid", 128'(keys_valid), 128'(0));
        chk("arst_rdkey", rd_key, 128'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_ready", 128'(ready), 128'(1));
        start_exp(K_SEQ);
        wait_done("post");
        rd("post_rk10", 4'd10, 1'b0, K_SEQ_A);
        rd("post_rev10", 4'd10, 1'b1, K_SEQ);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
